// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_array.sv
// Program storage: one synchronous write port, one asynchronous read port.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [AW-1:0]             i_waddr,
    input  logic [8*WORD_BYTES-1:0]   i_wdata,
    input  logic [AW-1:0]             i_raddr,
    output logic [8*WORD_BYTES-1:0]   o_rdata
);
    logic [8*WORD_BYTES-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory: valid/ready request, fixed wait states,
// registered response with misalign/out-of-range error.
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [31:0]              i_req_addr,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [31:0]              o_rsp_data,
    output logic                     o_rsp_err,
    input  logic                     i_ld_en,
    input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
    input  logic [31:0]              i_ld_data,
    output logic                     o_busy
);
    localparam int             AW       = $clog2(DEPTH);
    localparam int             WSH      = $clog2(WORD_BYTES);
    localparam int             CW       = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CW-1:0]  CNT_INIT = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;
    localparam logic [31:0]    DEPTH_W  = 32'(DEPTH);

    imem_state_t    r_state;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_addr;
    logic           r_rsp_valid;
    logic [31:0]    r_rsp_data;
    logic           r_rsp_err;
    logic           r_busy;

    logic           w_accept;
    logic [31:0]    w_addr;
    logic [31:0]    w_off;
    logic           w_err;
    logic [AW-1:0]  w_rd_idx;
    logic [31:0]    w_rd_data;
    logic [31:0]    w_rsp_data;

    assign o_req_ready = (r_state == IDLE) && !i_ld_en;
    assign w_accept    = i_req_valid && o_req_ready;

    // With zero wait states RESP is entered on the accept edge, so the
    // check must see the incoming address rather than the captured one.
    assign w_addr     = (r_state == IDLE) ? i_req_addr : r_addr;
    assign w_off      = w_addr - BASE_ADDR;
    assign w_err      = (|w_addr[WSH-1:0]) || ((w_off >> WSH) >= DEPTH_W);
    assign w_rd_idx   = w_off[AW+WSH-1:WSH];
    assign w_rsp_data = w_err ? 32'h0 : w_rd_data;

    imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk     (clk),
        .i_we    (i_ld_en),
        .i_waddr (i_ld_addr),
        .i_wdata (i_ld_data),
        .i_raddr (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr <= i_req_addr;
                        r_busy <= 1'b1;
                        if (LATENCY == 0) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= w_rsp_data;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    // Array read here sees every load committed before this edge.
                    if (r_cnt == '0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_rsp_data;
                        r_rsp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;
    assign o_busy      = r_busy;
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench: a LATENCY=2 instance for the main tests and a LATENCY=0
// instance for back-to-back throughput.
module tb_imem_responder;
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err, a_ld_en, a_busy;
    logic [31:0] a_req_addr, a_rsp_data, a_ld_data;
    logic [7:0]  a_ld_addr;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_ld_en, b_busy;
    logic [31:0] b_req_addr, b_rsp_data, b_ld_data;
    logic [7:0]  b_ld_addr;

    int   checks = 0;
    int   failures = 0;
    int   lat, bc, vcnt;
    exp_t q_a[$];
    exp_t q_b[$];

    imem_responder #(.DEPTH(256), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut_a (
        .clk(clk), .reset(reset),
        .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_addr(a_req_addr),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready), .o_rsp_data(a_rsp_data),
        .o_rsp_err(a_rsp_err), .i_ld_en(a_ld_en), .i_ld_addr(a_ld_addr),
        .i_ld_data(a_ld_data), .o_busy(a_busy)
    );

    imem_responder #(.DEPTH(256), .LATENCY(0), .BASE_ADDR(32'h0)) u_dut_b (
        .clk(clk), .reset(reset),
        .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_addr(b_req_addr),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready), .o_rsp_data(b_rsp_data),
        .o_rsp_err(b_rsp_err), .i_ld_en(b_ld_en), .i_ld_addr(b_ld_addr),
        .i_ld_data(b_ld_data), .o_busy(b_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_a(input logic [7:0] idx, input logic [31:0] d);
        a_ld_en = 1'b1; a_ld_addr = idx; a_ld_data = d;
        tick();
        a_ld_en = 1'b0;
    endtask

    task automatic ld_b(input logic [7:0] idx, input logic [31:0] d);
        b_ld_en = 1'b1; b_ld_addr = idx; b_ld_data = d;
        tick();
        b_ld_en = 1'b0;
    endtask

    // Starts at posedge+1 with instance A idle; returns at the first negedge
    // where rsp_valid is seen, reporting cycles since accept and busy cycles.
    task automatic fetch_a(input logic [31:0] addr, input logic [31:0] ed, input logic ee,
                           output int l, output int b);
        a_req_valid = 1'b1;
        a_req_addr  = addr;
        q_a.push_back(exp_t'{data: ed, err: ee});
        tick();
        a_req_valid = 1'b0;
        l = 0; b = 0;
        do begin
            @(negedge clk);
            l++;
            if (a_busy) b++;
        end while (!a_rsp_valid && l < 40);
        if (l >= 40) chk("a_rsp_timeout", 64'(a_rsp_valid), 64'd1);
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_rsp_valid && a_rsp_ready) begin
            if (q_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_rsp: got data %h err %0d, expected no response", a_rsp_data, a_rsp_err);
            end else begin
                e = q_a.pop_front();
                chk("a_rsp_data", 64'(a_rsp_data), 64'(e.data));
                chk("a_rsp_err", 64'(a_rsp_err), 64'(e.err));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_rsp_valid && b_rsp_ready) begin
            if (q_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_rsp: got data %h err %0d, expected no response", b_rsp_data, b_rsp_err);
            end else begin
                e = q_b.pop_front();
                chk("b_rsp_data", 64'(b_rsp_data), 64'(e.data));
                chk("b_rsp_err", 64'(b_rsp_err), 64'(e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        a_req_valid = 0; a_req_addr = 0; a_rsp_ready = 1; a_ld_en = 0; a_ld_addr = 0; a_ld_data = 0;
        b_req_valid = 0; b_req_addr = 0; b_rsp_ready = 1; b_ld_en = 0; b_ld_addr = 0; b_ld_data = 0;
        #3;
        chk("reset_a_outputs", {a_rsp_valid, a_rsp_err, a_busy, a_req_ready, a_rsp_data}, {4'b0001, 32'h0});
        chk("reset_b_outputs", {b_rsp_valid, b_rsp_err, b_busy, b_req_ready, b_rsp_data}, {4'b0001, 32'h0});
        tick(); tick();
        reset = 1'b0;
        tick();

        // Aligned fetch with latency and busy window
        ld_a(8'd3, 32'h0000_0513);
        ld_a(8'd4, 32'hDEAD_BEEF);
        ld_a(8'd255, 32'h1234_5678);
        fetch_a(32'h0000_000C, 32'h0000_0513, 1'b0, lat, bc);
        chk("aligned_latency", 64'(lat), 64'd3);
        chk("aligned_busy_cycles", 64'(bc), 64'd3);
        tick();
        chk("after_handshake_idle", {a_rsp_valid, a_busy, a_req_ready}, {3'b001});

        // Error and boundary addresses
        fetch_a(32'h0000_0006, 32'h0, 1'b1, lat, bc); tick();
        fetch_a(32'h0000_0400, 32'h0, 1'b1, lat, bc); tick();
        fetch_a(32'hFFFF_FFFC, 32'h0, 1'b1, lat, bc); tick();
        fetch_a(32'h0000_03FC, 32'h1234_5678, 1'b0, lat, bc); tick();

        // Backpressure: response held for 5 cycles
        a_rsp_ready = 1'b0;
        fetch_a(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, lat, bc);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("backpressure_hold", {a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_data},
                {3'b100, 32'hDEAD_BEEF});
        end
        @(posedge clk); #1;
        a_rsp_ready = 1'b1;
        tick();
        chk("backpressure_release", {a_rsp_valid, a_busy, a_req_ready}, {3'b001});

        // Load has priority over fetch
        a_ld_en = 1'b1; a_ld_addr = 8'd7; a_ld_data = 32'h0000_7777;
        a_req_valid = 1'b1; a_req_addr = 32'h0000_001C;
        @(negedge clk);
        chk("load_blocks_req_ready", 64'(a_req_ready), 64'd0);
        tick();
        chk("load_no_accept_busy", 64'(a_busy), 64'd0);
        a_ld_en = 1'b0; a_req_valid = 1'b0;
        fetch_a(32'h0000_001C, 32'h0000_7777, 1'b0, lat, bc); tick();

        // Load during WAIT before the final wait edge is visible
        ld_a(8'd5, 32'hAAAA_0001);
        fork
            fetch_a(32'h0000_0014, 32'hBBBB_0002, 1'b0, lat, bc);
            begin
                tick();
                a_ld_en = 1'b1; a_ld_addr = 8'd5; a_ld_data = 32'hBBBB_0002;
                tick();
                a_ld_en = 1'b0;
            end
        join
        tick();
        // Load on the RESP-entry edge returns the old word
        fork
            fetch_a(32'h0000_0014, 32'hBBBB_0002, 1'b0, lat, bc);
            begin
                tick(); tick();
                a_ld_en = 1'b1; a_ld_addr = 8'd5; a_ld_data = 32'hCCCC_0003;
                tick();
                a_ld_en = 1'b0;
            end
        join
        tick();
        fetch_a(32'h0000_0014, 32'hCCCC_0003, 1'b0, lat, bc); tick();

        // Reset while in WAIT discards the transaction
        a_req_valid = 1'b1; a_req_addr = 32'h0000_000C;
        tick();
        a_req_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("reset_mid_wait", {a_rsp_valid, a_busy}, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_rsp_valid) vcnt++;
        end
        chk("no_stale_rsp", 64'(vcnt), 64'd0);
        @(posedge clk); #1;
        fetch_a(32'h0000_000C, 32'h0000_0513, 1'b0, lat, bc);
        chk("post_reset_latency", 64'(lat), 64'd3);
        tick();

        // Zero-latency instance: back-to-back, one response every 2 cycles
        ld_b(8'd0, 32'h0000_0093);
        ld_b(8'd1, 32'h0010_0113);
        q_b.push_back(exp_t'{data: 32'h0000_0093, err: 1'b0});
        q_b.push_back(exp_t'{data: 32'h0010_0113, err: 1'b0});
        b_req_valid = 1'b1; b_req_addr = 32'h0;
        tick();
        b_req_addr = 32'h4;
        @(negedge clk);
        chk("lat0_first_valid", 64'(b_rsp_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat0_gap_cycle", {b_rsp_valid, b_req_ready}, 2'b01);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        @(negedge clk);
        chk("lat0_second_valid", 64'(b_rsp_valid), 64'd1);
        tick();
        chk("lat0_done", {b_rsp_valid, b_busy}, 2'b00);

        tick();
        chk("a_queue_drained", 64'(q_a.size()), 64'd0);
        chk("b_queue_drained", 64'(q_b.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder on the fetch side of the single-cycle/multicycle core. It accepts a word address from the fetch stage (driven by the PC) via a valid/ready request channel, and stores the program in an internal word array. After a configurable number of wait states it returns the instruction word, with an error flag for misaligned or out-of-range addresses, on a valid/ready response channel. A separate load port writes the program image before or during execution.

## Interface
- DEPTH, 256: number of 32-bit words stored; power of two, ≥ 4.
- LATENCY, 2: wait cycles between request acceptance and response; range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0; must be word-aligned.

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  32  byte address of instruction
- rsp_valid  out  1  response present
- rsp_ready  in  1  fetch stage consumes response
- rsp_data  out  32  instruction word; 0 when rsp_err=1
- rsp_err  out  1  misaligned or out-of-range address
- ld_en  in  1  program-load write strobe
- ld_addr  in  $clog2(DEPTH)  word index for load
- ld_data  in  32  word to write
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- Request handshake:
  - req_ready = (state==IDLE) & ~ld_en. Load has priority over fetch.
  - A request is accepted on the edge where req_valid & req_ready = 1. req_addr is captured into an address register.
- State transitions:
  - IDLE→WAIT on accept if LATENCY>0. The wait counter is loaded with LATENCY-1.
  - IDLE→RESP on accept if LATENCY=0.
  - WAIT: the counter decrements each cycle. When the counter = 0, the next state is RESP.
  - RESP: hold until rsp_valid & rsp_ready, then →IDLE.
- No new request is accepted in the same cycle as a response handshake.
- Error check, performed on the captured address:
  - misaligned when addr[1:0] ≠ 0;
  - out of range when (addr − BASE_ADDR) >> 2 ≥ DEPTH (unsigned, 32-bit wrap).
  - Either condition sets rsp_err=1 and rsp_data=0.
- Response latching:
  - rsp_data and rsp_err are registered on the transition into RESP.
  - Both stay stable while rsp_valid=1 and rsp_ready=0.
- Load port:
  - The write occurs on any edge where ld_en=1, regardless of state.
  - A load to the word being read, on the same edge as the transition into RESP, returns the old value (read-before-write).
  - Loads during WAIT that occur earlier than that edge are visible in the response.
- Reset:
  - Outputs: rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, state IDLE, counter 0.
  - req_ready=1 if ld_en=0.
  - Memory contents are not reset.
  - Reset mid-transaction discards the transaction. No response is ever produced for it.

## Timing
- Request latency: request sampled at edge E0 → rsp_valid high after edge E(LATENCY). That is, rsp_valid is first seen LATENCY+1 cycles after the accept cycle.
- Throughput: at most one transaction per LATENCY+2 cycles when rsp_ready is held high.
- rsp_valid deasserts on the edge after the response handshake. req_ready rises in that same cycle if ld_en=0.
- All outputs are registered except req_ready, which is combinational from the state register and ld_en.

## Structure
- Package imem_pkg holds:
  - state enum imem_state_t {IDLE, WAIT, RESP};
  - localparam WORD_BYTES=4.
- Counter width is $clog2(LATENCY+1), minimum 1.
- Sub-module imem_array: DEPTH×32 storage with one synchronous write port and one asynchronous read port.
- The FSM, address register, range check and response registers live in imem_responder.

## Test plan
- Aligned fetch: load word 3 = 32'h0000_0513, LATENCY=2, BASE=0, fetch 0x0C with rsp_ready=1 → rsp_valid first high 3 cycles after accept, rsp_data=32'h0000_0513, rsp_err=0, busy high for 3 cycles.
- Errors: fetch 0x0000_0006 → rsp_err=1, rsp_data=0. Fetch 0x0000_0400 with DEPTH=256 → rsp_err=1. Fetch BASE−4 (wrap) → rsp_err=1.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_data and rsp_err held constant, and req_ready=0 throughout. Handshake → IDLE and req_ready=1 next cycle.
- Load priority and ordering:
  - ld_en=1 with req_valid=1 in IDLE → req_ready=0 and no accept.
  - Load to word N during WAIT, before the final wait cycle → response returns the new value.
  - Load to word N on the RESP-entry edge → response returns the old value.
- Reset mid-operation: assert reset in WAIT → rsp_valid=0, busy=0 immediately. After release, no stale response appears, and a new fetch completes with LATENCY+1 timing.
- LATENCY=0 build: back-to-back fetches of 0x0, 0x4 with rsp_ready=1 → one response every 2 cycles, data matches the loaded words.
